// File: rtl/seq_detect_prog.sv
// Programmable serial-bit sequence detector with per-bit compare mask,
// overlap/non-overlap modes, a registered match pulse and a saturating counter.
module seq_detect_prog #(
    parameter int LEN   = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_vld,
    input  logic             new_bit,
    input  logic             cfg_we,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic [LEN-1:0]   cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             detected,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);

    logic [LEN-1:0]   pattern_q, pattern_d;
    logic [LEN-1:0]   mask_q, mask_d;
    logic             overlap_q, overlap_d;
    logic [LEN-1:0]   sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [LEN-1:0]   sr_next;
    logic [FW-1:0]    fill_next;
    logic             hit;

    // Candidate window and fill level if the current bit were accepted.
    always_comb begin
        sr_next   = {sr_q[LEN-2:0], new_bit};
        fill_next = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
        hit = bit_vld && !cfg_we && (fill_next == FULL) &&
              (((sr_next ^ pattern_q) & mask_q) == '0);
    end

    // Next-state for config, window, fill, pulse and counter.
    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        overlap_d = overlap_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        det_d     = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_we) begin
            pattern_d = cfg_pattern;
            mask_d    = cfg_mask;
            overlap_d = cfg_overlap;
            sr_d      = '0;
            fill_d    = '0;
        end else if (bit_vld) begin
            sr_d  = sr_next;
            det_d = hit;
            // Non-overlap: the matched bits are consumed by this hit.
            fill_d = (hit && !overlap_q) ? '0 : fill_next;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            mask_q    <= '1;
            overlap_q <= 1'b1;
            sr_q      <= '0;
            fill_q    <= '0;
            det_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            overlap_q <= overlap_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            det_q     <= det_d;
            cnt_q     <= cnt_d;
        end
    end

    assign detected  = det_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: two instances (LEN=6/CNT_W=8, LEN=4/CNT_W=2)
// driven by one stream and compared against a bit-history reference model.
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_vld = 1'b0;
    logic       new_bit = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_overlap = 1'b1;
    logic       cnt_clr = 1'b0;
    logic [5:0] cfg_pat6 = '0;
    logic [5:0] cfg_msk6 = '1;
    logic [3:0] cfg_pat4 = '0;
    logic [3:0] cfg_msk4 = '1;

    logic       det0, sat0, det1, sat1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state, index 0 = LEN 6, index 1 = LEN 4
    int        mn[2];
    bit [31:0] mh[2];
    bit [31:0] mp[2];
    bit [31:0] mm[2];
    bit        mo[2];
    bit        md[2];
    int        mc[2];

    always #5 clk = ~clk;

    seq_detect_prog #(.LEN(6), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .new_bit(new_bit),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pat6), .cfg_mask(cfg_msk6),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .detected(det0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    seq_detect_prog #(.LEN(4), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .new_bit(new_bit),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pat4), .cfg_mask(cfg_msk4),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .detected(det1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; mh[k] = 0; mp[k] = 0; mm[k] = '1;
            mo[k] = 1'b1; md[k] = 1'b0; mc[k] = 0;
        end
    endtask

    // Match = last L accepted bits since the window start agree with the
    // pattern on every masked position.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int L, maxc;
            bit [31:0] lowm;
            bit h;
            L = (k == 0) ? 6 : 4;
            maxc = (k == 0) ? 255 : 3;
            lowm = (32'd1 << L) - 1;
            h = 1'b0;
            if (cfg_we) begin
                mp[k] = (k == 0) ? 32'(cfg_pat6) : 32'(cfg_pat4);
                mm[k] = (k == 0) ? 32'(cfg_msk6) : 32'(cfg_msk4);
                mo[k] = cfg_overlap;
                mn[k] = 0;
                mh[k] = 0;
            end else if (bit_vld) begin
                mh[k] = (mh[k] << 1) | 32'(new_bit);
                if (mn[k] < 1000) mn[k]++;
                h = (mn[k] >= L) && (((mh[k] ^ mp[k]) & mm[k] & lowm) == 0);
                if (h && !mo[k]) mn[k] = 0;
            end
            md[k] = h;
            if (cnt_clr) mc[k] = 0;
            else if (h && mc[k] < maxc) mc[k]++;
        end
    endtask

    task automatic check_all();
        chk("det0", int'(det0), int'(md[0]));
        chk("cnt0", int'(cnt0), mc[0]);
        chk("sat0", int'(sat0), int'(mc[0] == 255));
        chk("det1", int'(det1), int'(md[1]));
        chk("cnt1", int'(cnt1), mc[1]);
        chk("sat1", int'(sat1), int'(mc[1] == 3));
    endtask

    task automatic step(input bit vld, input bit b, input bit we,
                        input bit clr);
        bit_vld = vld; new_bit = b; cfg_we = we; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cfg(input bit [5:0] p6, input bit [5:0] m6,
                       input bit [3:0] p4, input bit [3:0] m4,
                       input bit o);
        cfg_pat6 = p6; cfg_msk6 = m6;
        cfg_pat4 = p4; cfg_msk4 = m4;
        cfg_overlap = o;
        step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // send n bits of v, oldest (bit n-1) first, with gap idle cycles after each
    task automatic send(input bit [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, v[i], 1'b0, 1'b0);
            repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();

        // basic detection
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b0110011, 7, 0);
        chk("t1_det", int'(det0), 1);
        chk("t1_cnt", int'(cnt0), 1);

        // overlap vs non-overlap on LEN 4
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b10101010, 8, 0);
        chk("ovl_cnt", int'(cnt1), 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b0);
        send(32'b10101010, 8, 0);
        chk("novl_cnt", int'(cnt1), 2);

        // mask
        cfg(6'b110011, 6'b111011, 4'b1010, 4'b1111, 1'b1);
        send(32'b110011, 6, 0);
        chk("mask_a", int'(det0), 1);
        cfg(6'b110011, 6'b111011, 4'b1010, 4'b1111, 1'b1);
        send(32'b110111, 6, 0);
        chk("mask_b", int'(det0), 1);
        cfg(6'b110011, 6'b111011, 4'b1010, 4'b1111, 1'b1);
        send(32'b100011, 6, 0);
        chk("mask_c", int'(det0), 0);

        // idle gaps are transparent
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b110011, 6, 3);
        chk("gap_cnt", int'(cnt0), 1);

        // config mid-stream restarts the window
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b11001, 5, 0);
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b1, 1, 0);
        chk("cfgmid_det", int'(det0), 0);
        send(32'b110011, 6, 0);
        chk("cfgmid_det2", int'(det0), 1);
        chk("cfgmid_cnt", int'(cnt0), 1);

        // reset mid-stream
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b11001, 5, 0);
        do_reset();
        send(32'b1, 1, 0);
        chk("rst_det", int'(det0), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_sat", int'(sat0), 0);

        // counter saturation on CNT_W=2
        cfg(6'b110011, 6'b111111, 4'b1010, 4'b1111, 1'b1);
        send(32'b1010101010, 10, 0);
        chk("sat_cnt", int'(cnt1), 3);
        chk("sat_flag", int'(sat1), 1);

        // clear wins over a same-cycle hit
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_det", int'(det1), 1);
        chk("clr_cnt", int'(cnt1), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cfg(6'($urandom), ($urandom_range(0, 7) == 0) ? 6'd0 :
                    6'($urandom | $urandom), 4'($urandom),
                    4'($urandom | $urandom), 1'($urandom));
            end else if (r < 4) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                     1'b0, $urandom_range(0, 29) == 0);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial-bit sequence detector: the parametrised successor to the fixed-pattern shift-register detectors in the FSM exercises. It compares the last LEN accepted bits against a runtime-loaded pattern with a per-bit compare mask, in overlapping or non-overlapping mode. It reports each match as a one-cycle registered pulse and keeps a saturating match counter. It sits directly on a serial bit stream with a valid qualifier.

## Interface
- LEN, 6: pattern length in bits, legal 2..32.
- CNT_W, 8: match counter width, legal 1..32.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- bit_vld  in  1  new_bit is accepted on this edge when high.
- new_bit  in  1  serial data bit.
- cfg_we  in  1  load configuration this cycle.
- cfg_pattern  in  LEN  pattern; bit LEN-1 = oldest bit, bit 0 = newest bit.
- cfg_mask  in  LEN  1 = compare this position, 0 = don't care.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- detected  out  1  one-cycle match pulse (registered).
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  high while match_cnt is at all-ones.

## Operation
- State:
  - config registers pattern_q, mask_q, overlap_q.
  - shift register sr[LEN-1:0]; newest bit enters at bit 0, oldest bit is at bit LEN-1.
  - fill counter fill, range 0..LEN, saturates at LEN.
  - detected register and match counter.
- Reset values (applied asynchronously while rst_n is low):
  - pattern_q = 0, mask_q = all ones, overlap_q = 1.
  - sr = 0, fill = 0, detected = 0, match_cnt = 0, cnt_sat = 0.
- Config write (cfg_we = 1):
  - Load pattern_q, mask_q and overlap_q.
  - Clear sr and fill.
  - The same-cycle bit_vld is ignored: no shift, no match, detected = 0 on the next cycle.
- Bit accept (bit_vld = 1, cfg_we = 0):
  - sr_next = {sr[LEN-2:0], new_bit}.
  - fill_next = min(fill + 1, LEN).
  - hit = (fill_next == LEN) and (((sr_next XOR pattern_q) AND mask_q) == 0).
  - sr <= sr_next; detected <= hit.
  - If hit and overlap_q = 0: fill <= 0, so the next match needs LEN fresh bits. Otherwise fill <= fill_next.
- bit_vld = 0: sr and fill hold; detected <= 0.
- A match is never reported before LEN bits have been accepted since reset, the last config write, or the last non-overlap match.
- mask_q = 0: every accepted bit with fill_next == LEN is a hit. This behaviour is legal and defined.
- Counter:
  - cnt_clr has priority: match_cnt <= 0, even when a hit occurs in the same cycle.
  - Otherwise, on hit: match_cnt <= match_cnt + 1, holding at 2^CNT_W - 1.
  - cnt_sat = (match_cnt == all ones); it is a combinational decode of the register.
- Config writes do not affect match_cnt.

## Timing
- Latency: a completing bit accepted at edge N gives detected = 1 and the updated match_cnt during cycle N+1, i.e. until edge N+1.
- detected lasts exactly one cycle per hit. Back-to-back hits (overlap mode) give consecutive high cycles.
- Reset mid-stream: all state clears immediately and asynchronously. Bits accepted before reset can never contribute to a match.
- Config takes effect for the bit accepted at the edge after the cfg_we edge.
- Gaps in bit_vld are transparent: matching spans any number of idle cycles.

## Test plan
- Default, LEN=6: load pattern 110011 with mask 111111, then stream 0110011 with bit_vld continuously high -> detected pulses once, one cycle after the seventh bit; match_cnt = 1.
- Overlap, LEN=4: pattern 1010, overlap = 1, stream 10101010 -> hits after bits 4, 6 and 8; match_cnt = 3. Same stream with overlap = 0 -> hits after bits 4 and 8 only; match_cnt = 2.
- Mask: pattern 110011, mask 111011 -> both 110011 and 110111 match; 100011 does not match.
- Gaps and config: stream 110011 with bit_vld low for 3 cycles between every bit -> exactly one pulse. Assert cfg_we after 5 bits of a 110011 stream -> no match until 6 new bits arrive.
- Reset and saturation:
  - Pulse rst_n low after 5 matching bits, then send the 6th bit -> no detection; all outputs read 0.
  - CNT_W=2 with 5 hits -> match_cnt = 3 and cnt_sat = 1.
  - cnt_clr in the same cycle as a hit -> match_cnt = 0.
